// File: rtl/stream_select_mux.sv
// stream_select_mux: registered N-channel valid/ready stream selector (explicit select or round-robin); STREAM_MUX_STATS_EN adds xfer_count
module stream_select_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 3,
    parameter int SELW     = 2,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef STREAM_MUX_STATS_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

    logic [SELW-1:0]  last_grant;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  cand;
    logic             grant_ok;
    logic             can_load;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] words [CHANNELS];

    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_words
        assign words[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Grant: clamped select code, or the nearest valid channel after last_grant (reverse scan so the nearest wins)
    always_comb begin
        grant    = LAST;
        grant_ok = 1'b0;
        cand     = '0;
        if (MODE == 0) begin
            grant    = (32'(sel) < CHANNELS) ? sel : LAST;
            grant_ok = 1'b1;
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                cand = SELW'((int'(last_grant) + k) % CHANNELS);
                if (in_valid[cand]) begin
                    grant    = cand;
                    grant_ok = 1'b1;
                end
            end
        end
    end

    assign can_load = !out_valid || out_ready;
    assign in_fire  = !rst && grant_ok && can_load && in_valid[grant];
    assign out_fire = out_valid && out_ready;
    assign in_ready = (!rst && grant_ok && can_load) ? (CHANNELS'(1) << grant) : '0;

    // One-entry output register: load on input handshake, drain on output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= LAST;
        end else if (in_fire) begin
            out_valid  <= 1'b1;
            out_data   <= words[grant];
            out_chan   <= grant;
            last_grant <= grant;
        end else if (out_fire) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef STREAM_MUX_STATS_EN
    // Saturating count of output handshakes
    always_ff @(posedge clk) begin
        if (rst)
            xfer_count <= '0;
        else if (out_fire && xfer_count != 16'hFFFF)
            xfer_count <= xfer_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_stream_select_mux.sv
// tb_stream_select_mux: randomized and directed checks of an explicit-select and a round-robin instance against a behavioural model
module tb_stream_select_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = '0;
    logic [95:0] in_data = '0;
    logic [2:0]  in_valid = '0;
    logic        ready_a = 1'b0;
    logic        ready_b = 1'b0;

    logic [2:0]  a_in_ready, b_in_ready;
    logic [31:0] a_out_data, b_out_data;
    logic [1:0]  a_out_chan, b_out_chan;
    logic        a_out_valid, b_out_valid;
`ifdef STREAM_MUX_STATS_EN
    logic [15:0] a_xfer, b_xfer;
`endif

    int errors = 0;
    int checks = 0;

    logic        ma_valid = 1'b0, mb_valid = 1'b0;
    logic [31:0] ma_data = '0, mb_data = '0;
    int          ma_chan = 0, mb_chan = 0, mb_last = 2, m_count = 0;

    always #5 clk = ~clk;

    stream_select_mux #(.WIDTH(32), .CHANNELS(3), .SELW(2), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_chan(a_out_chan),
        .out_valid(a_out_valid), .out_ready(ready_a)
`ifdef STREAM_MUX_STATS_EN
        , .xfer_count(a_xfer)
`endif
    );

    stream_select_mux #(.WIDTH(32), .CHANNELS(3), .SELW(2), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_chan(b_out_chan),
        .out_valid(b_out_valid), .out_ready(ready_b)
`ifdef STREAM_MUX_STATS_EN
        , .xfer_count(b_xfer)
`endif
    );

    function automatic logic [31:0] word(int c);
        return in_data[c*32 +: 32];
    endfunction

    function automatic int grant_a();
        return (sel < 2'd3) ? int'(sel) : 2;
    endfunction

    function automatic int grant_b();
        for (int k = 1; k <= 3; k++)
            if (in_valid[(mb_last + k) % 3]) return (mb_last + k) % 3;
        return -1;
    endfunction

    function automatic logic [2:0] exp_ready_a();
        if (rst || (ma_valid && !ready_a)) return 3'b000;
        return 3'(1 << grant_a());
    endfunction

    function automatic logic [2:0] exp_ready_b();
        if (rst || (mb_valid && !ready_b) || grant_b() < 0) return 3'b000;
        return 3'(1 << grant_b());
    endfunction

    // Advance one clock: model next state from the current inputs, then commit after the edge
    task automatic tick();
        logic        na_v, nb_v;
        logic [31:0] na_d, nb_d;
        int          na_c, nb_c, nb_l, nc, g;
        na_v = ma_valid; na_d = ma_data; na_c = ma_chan;
        nb_v = mb_valid; nb_d = mb_data; nb_c = mb_chan; nb_l = mb_last; nc = m_count;
        if (rst) begin
            na_v = 0; na_d = 0; na_c = 0; nb_v = 0; nb_d = 0; nb_c = 0; nb_l = 2; nc = 0;
        end else begin
            if (ma_valid && ready_a && nc < 65535) nc++;
            g = grant_a();
            if (in_valid[g] && (!ma_valid || ready_a)) begin
                na_v = 1; na_d = word(g); na_c = g;
            end else if (ma_valid && ready_a) na_v = 0;
            g = grant_b();
            if (g >= 0 && (!mb_valid || ready_b)) begin
                nb_v = 1; nb_d = word(g); nb_c = g; nb_l = g;
            end else if (mb_valid && ready_b) nb_v = 0;
        end
        @(posedge clk);
        #1;
        ma_valid = na_v; ma_data = na_d; ma_chan = na_c;
        mb_valid = nb_v; mb_data = nb_d; mb_chan = nb_c; mb_last = nb_l; m_count = nc;
    endtask

    task automatic test_reset();
        rst = 1; sel = 0; in_valid = 3'b111; ready_a = 1; ready_b = 1;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++; if (a_in_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_a: got %b want 000", a_in_ready); end
            checks++; if (b_in_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_b: got %b want 000", b_in_ready); end
            tick();
        end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", a_out_data); end
        checks++; if (a_out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", a_out_chan); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", b_out_valid); end
        rst = 0;
    endtask

    task automatic test_select();
        in_data = {32'hC, 32'hB, 32'hA}; in_valid = 3'b111; ready_a = 1; sel = 2'd1;
        #1; tick();
        checks++; if (a_out_data !== 32'hB || a_out_chan !== 2'd1 || a_out_valid !== 1'b1) begin errors++; $display("FAIL sel1: got %h/%0d/%b want 0000000b/1/1", a_out_data, a_out_chan, a_out_valid); end
        sel = 2'd3;
        #1;
        checks++; if (a_in_ready !== 3'b100) begin errors++; $display("FAIL clamp_ready: got %b want 100", a_in_ready); end
        tick();
        checks++; if (a_out_data !== 32'hC || a_out_chan !== 2'd2) begin errors++; $display("FAIL clamp: got %h/%0d want 0000000c/2", a_out_data, a_out_chan); end
    endtask

    task automatic test_backpressure();
        sel = 2'd0; in_data[31:0] = 32'h1234; ready_a = 1;
        #1; tick();
        checks++; if (a_out_data !== 32'h1234) begin errors++; $display("FAIL bp_load: got %h want 00001234", a_out_data); end
        ready_a = 0; in_data[31:0] = 32'h5678;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++; if (a_in_ready !== 3'b000) begin errors++; $display("FAIL bp_ready: got %b want 000", a_in_ready); end
            tick();
            checks++; if (a_out_data !== 32'h1234 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b want 00001234/1", a_out_data, a_out_valid); end
        end
        ready_a = 1;
        #1;
        checks++; if (a_in_ready !== 3'b001) begin errors++; $display("FAIL bp_release_ready: got %b want 001", a_in_ready); end
        tick();
        checks++; if (a_out_data !== 32'h5678 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_reload: got %h/%b want 00005678/1", a_out_data, a_out_valid); end
    endtask

    task automatic test_round_robin();
        rst = 1; #1; tick(); rst = 0;
        in_valid = 3'b111; ready_b = 1;
        for (int n = 0; n < 6; n++) begin
            #1; tick();
            checks++; if (b_out_chan !== 2'(n % 3) || b_out_valid !== 1'b1) begin errors++; $display("FAIL rr_seq%0d: got %0d/%b want %0d/1", n, b_out_chan, b_out_valid, n % 3); end
        end
        in_valid = 3'b100;
        for (int n = 0; n < 3; n++) begin
            #1; tick();
            checks++; if (b_out_chan !== 2'd2 || b_out_data !== word(2)) begin errors++; $display("FAIL rr_only2: got %0d/%h want 2/%h", b_out_chan, b_out_data, word(2)); end
        end
        in_valid = 3'b000;
        #1;
        checks++; if (b_in_ready !== 3'b000) begin errors++; $display("FAIL rr_idle_ready: got %b want 000", b_in_ready); end
        tick();
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_valid: got %b want 0", b_out_valid); end
    endtask

    task automatic test_reset_mid();
        in_valid = 3'b111; ready_b = 1;
        #1; tick(); #1; tick();
        ready_b = 0;
        #1; tick();
        checks++; if (b_out_valid !== 1'b1 || b_out_chan !== 2'd1) begin errors++; $display("FAIL mid_held: got %b/%0d want 1/1", b_out_valid, b_out_chan); end
        rst = 1;
        #1;
        checks++; if (b_in_ready !== 3'b000) begin errors++; $display("FAIL mid_rst_ready: got %b want 000", b_in_ready); end
        tick(); rst = 0;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", b_out_valid); end
        ready_b = 1;
        #1; tick();
        checks++; if (b_out_chan !== 2'd0 || b_out_valid !== 1'b1) begin errors++; $display("FAIL mid_first_grant: got %0d/%b want 0/1", b_out_chan, b_out_valid); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_data  = {$urandom, $urandom, $urandom};
            in_valid = 3'($urandom);
            sel      = 2'($urandom);
            ready_a  = 1'($urandom);
            ready_b  = 1'($urandom);
            rst      = ($urandom_range(0, 40) == 0);
            #1;
            checks++; if (a_in_ready !== exp_ready_a()) begin errors++; $display("FAIL rnd_ready_a@%0d: got %b want %b", n, a_in_ready, exp_ready_a()); end
            checks++; if (b_in_ready !== exp_ready_b()) begin errors++; $display("FAIL rnd_ready_b@%0d: got %b want %b", n, b_in_ready, exp_ready_b()); end
            tick();
            checks++; if (a_out_valid !== ma_valid || (ma_valid && (a_out_data !== ma_data || a_out_chan !== 2'(ma_chan)))) begin errors++; $display("FAIL rnd_out_a@%0d: got %b/%h/%0d want %b/%h/%0d", n, a_out_valid, a_out_data, a_out_chan, ma_valid, ma_data, ma_chan); end
            checks++; if (b_out_valid !== mb_valid || (mb_valid && (b_out_data !== mb_data || b_out_chan !== 2'(mb_chan)))) begin errors++; $display("FAIL rnd_out_b@%0d: got %b/%h/%0d want %b/%h/%0d", n, b_out_valid, b_out_data, b_out_chan, mb_valid, mb_data, mb_chan); end
`ifdef STREAM_MUX_STATS_EN
            checks++; if (a_xfer !== 16'(m_count)) begin errors++; $display("FAIL rnd_xfer@%0d: got %0d want %0d", n, a_xfer, m_count); end
`endif
        end
        rst = 0;
    endtask

`ifdef STREAM_MUX_STATS_EN
    task automatic test_stats();
        rst = 1; #1; tick(); rst = 0;
        in_valid = 3'b111; ready_a = 1; sel = 2'd0;
        repeat (70000) tick();
        checks++; if (a_xfer !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", a_xfer); end
        repeat (5) tick();
        checks++; if (a_xfer !== 16'hFFFF) begin errors++; $display("FAIL stats_hold: got %h want ffff", a_xfer); end
        rst = 1; #1; tick(); rst = 0;
        checks++; if (a_xfer !== 16'h0000) begin errors++; $display("FAIL stats_clear: got %h want 0000", a_xfer); end
    endtask
`endif

    initial begin
        test_reset();
        test_select();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        test_random();
`ifdef STREAM_MUX_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_select_mux.md
# stream_select_mux

Parametrised, registered N-channel operand/stream selector that replaces the fixed 3-input, 32-bit combinational datapath mux. It selects one of CHANNELS valid/ready input streams, either by an explicit select code or by round-robin arbitration, and delivers the chosen word through a one-entry output register. It sits between producer stages (register file, ALU, memory read path) and a single consumer in the datapath.

## Interface
- WIDTH, 32, data width in bits of every channel and of the output
- CHANNELS, 3, number of input channels (2..16)
- SELW, 2, width of select/channel codes; must satisfy 2^SELW >= CHANNELS
- MODE, 0, 0 = explicit select via sel, 1 = round-robin arbitration (sel ignored)

- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- sel  input  SELW  channel select code (MODE 0 only)
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle
- out_data  output  WIDTH  registered selected word
- out_chan  output  SELW  index of the channel that produced out_data
- out_valid  output  1  out_data/out_chan hold a beat
- out_ready  input  1  consumer accepts the beat
- xfer_count  output  16  output handshake count (present only with STREAM_MUX_STATS_EN)

## Operation
- Output register holds one beat. can_load = !out_valid || out_ready.
- Grant g per cycle:
  - MODE 0: g = sel if sel < CHANNELS, else g = CHANNELS-1 (out-of-range codes clamp to the highest channel).
  - MODE 1: g = first i with in_valid[i] set, searching last_grant+1, last_grant+2, … modulo CHANNELS; no grant if no channel is valid.
- in_ready[g] = can_load (combinational from out_ready); all other in_ready bits are 0. MODE 1 with no valid channel: all in_ready are 0.
- Input handshake on channel g (in_valid[g] && in_ready[g]): out_data <= channel g word, out_chan <= g, out_valid <= 1, last_grant <= g.
- Output handshake (out_valid && out_ready) without a simultaneous input handshake: out_valid <= 0; out_data/out_chan retain their values.
- Simultaneous output and input handshakes: new beat replaces the old one, out_valid stays 1 (full throughput).
- While out_valid && !out_ready: out_data, out_chan, out_valid are stable; no in_ready asserted.
- last_grant changes only on an input handshake; it is unused in MODE 0.

## Timing
- Reset (rst high at edge): out_valid=0, out_data=0, out_chan=0, last_grant=CHANNELS-1 (channel 0 wins first in MODE 1), xfer_count=0. Reset mid-transfer discards the held beat; in_ready is 0 throughout the reset cycle.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle while out_ready is held high and the granted channel is valid.
- sel is sampled in the same cycle as the input handshake; a change takes effect immediately on the next grant.
- No combinational path from in_data to out_data.

## Configuration
- STREAM_MUX_STATS_EN defined: xfer_count port exists; it increments on every output handshake, saturates at 16'hFFFF, and clears on rst.
- Undefined: xfer_count port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset: WIDTH=32, CHANNELS=3, MODE 0; rst high 2 cycles -> out_valid=0, out_data=0, out_chan=0, in_ready=3'b000 during reset.
- Explicit select and clamp: MODE 0, out_ready=1, all valid, in_data = {32'hC, 32'hB, 32'hA}; sel=1 -> out_data=32'hB, out_chan=1 next cycle; sel=3 -> out_data=32'hC, out_chan=2.
- Backpressure: out_ready=0 after a beat 32'h1234 loads -> out_data stays 32'h1234, in_ready=0 for 5 cycles; out_ready=1 -> beat drains, next beat loads in the same cycle.
- Round-robin fairness: MODE 1, all three valid, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,0,1,2; with only channel 2 valid -> 2,2,2.
- Reset mid-operation: out_valid=1, out_ready=0, assert rst 1 cycle -> out_valid=0 next cycle; MODE 1 next grant goes to channel 0.
- Stats (macro defined): 70000 back-to-back output handshakes -> xfer_count=16'hFFFF and holds; rst -> 0.
